// File: rtl/framebuffer_reader_if.sv
// Signal bundle tying the framebuffer scan-out reader to its RAM read port,
// the frame-start control and the downstream pixel consumer.
interface framebuffer_reader_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_ren;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_sof;
  logic              pix_eol;
  logic              busy;
  logic              frame_done;
  logic [1:0]        dbg_state;

  // Pixel handshake: a beat transfers on a rising edge where pix_valid && pix_ready.
  // While pix_valid && !pix_ready, pix_data/pix_sof/pix_eol stay frozen and
  // pix_valid stays high; pix_valid never depends combinationally on pix_ready.
  modport master (
    input  start, ram_rdata, pix_ready,
    output ram_addr, ram_ren, pix_data, pix_valid, pix_sof, pix_eol,
           busy, frame_done, dbg_state
  );

  modport slave (
    output start, ram_rdata, pix_ready,
    input  ram_addr, ram_ren, pix_data, pix_valid, pix_sof, pix_eol,
           busy, frame_done, dbg_state
  );
endinterface

// File: rtl/framebuffer_reader.sv
// Raster-order scan-out of a WIDTHxHEIGHT framebuffer: sequential RAM reads
// feed a 2-entry FIFO that streams tagged pixels over valid/ready.
module framebuffer_reader #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
) (
  input logic                  clk,
  input logic                  reset,
  framebuffer_reader_if.master bus
);
  localparam int NPIX = WIDTH * HEIGHT;
  localparam int XW   = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [XW-1:0]     LAST_X    = XW'(WIDTH - 1);
  localparam logic [YW-1:0]     LAST_Y    = YW'(HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic              r_pend;
  logic              r_pend_sof;
  logic              r_pend_eol;
  logic [DATA_W-1:0] r_fifo_data [2];
  logic              r_fifo_sof  [2];
  logic              r_fifo_eol  [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;
  logic              r_frame_done;

  logic              w_start_ok;
  logic              w_pop;
  logic [2:0]        w_credit;
  logic              w_issue;
  logic              w_last_issue;
  logic              w_last_pop;

  assign w_start_ok   = (r_state == S_IDLE) && bus.start && !r_frame_done;
  assign w_pop        = (r_count != 2'd0) && bus.pix_ready;
  // Entries that will occupy the FIFO after this edge if nothing new is issued.
  assign w_credit     = {1'b0, r_count} + {2'b00, r_pend} - {2'b00, w_pop};
  assign w_issue      = (r_state == S_FETCH) && (w_credit < 3'd2);
  assign w_last_issue = w_issue && (r_addr == LAST_ADDR);
  assign w_last_pop   = (r_state == S_DRAIN) && w_pop && (r_count == 2'd1) && !r_pend;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok)   w_state_nxt = S_FETCH;
      S_FETCH: if (w_last_issue) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_last_pop)   w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
      r_x    <= '0;
      r_y    <= '0;
    end else if (w_start_ok || w_last_issue) begin
      r_addr <= '0;
      r_x    <= '0;
      r_y    <= '0;
    end else if (w_issue) begin
      r_addr <= r_addr + 1'b1;
      if (r_x == LAST_X) begin
        r_x <= '0;
        r_y <= (r_y == LAST_Y) ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  // Tags ride alongside the read so they land in the FIFO with their pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend       <= 1'b0;
      r_pend_sof   <= 1'b0;
      r_pend_eol   <= 1'b0;
      r_wptr       <= 1'b0;
      r_rptr       <= 1'b0;
      r_count      <= 2'd0;
      r_frame_done <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_sof[i]  <= 1'b0;
        r_fifo_eol[i]  <= 1'b0;
      end
    end else begin
      r_pend <= w_issue;
      if (w_issue) begin
        r_pend_sof <= (r_addr == '0);
        r_pend_eol <= (r_x == LAST_X);
      end
      if (r_pend) begin
        r_fifo_data[r_wptr] <= bus.ram_rdata;
        r_fifo_sof[r_wptr]  <= r_pend_sof;
        r_fifo_eol[r_wptr]  <= r_pend_eol;
        r_wptr              <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_count      <= r_count + {1'b0, r_pend} - {1'b0, w_pop};
      r_frame_done <= w_last_pop;
    end
  end

  assign bus.ram_addr   = r_addr;
  assign bus.ram_ren    = w_issue;
  assign bus.pix_valid  = (r_count != 2'd0);
  assign bus.pix_data   = r_fifo_data[r_rptr];
  assign bus.pix_sof    = (r_count != 2'd0) && r_fifo_sof[r_rptr];
  assign bus.pix_eol    = (r_count != 2'd0) && r_fifo_eol[r_rptr];
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.frame_done = r_frame_done;
  assign bus.dbg_state  = r_state;
endmodule
